pixel_pack_3to24: RTL

Write-side packer for the 3-bit-per-pixel VGA frame store. It accepts a stream of 3-bit pixels addressed by a 19-bit pixel address and packs eight consecutive pixels into one 24-bit memory word. It then issues a single masked word write toward the frame memory. It sits between the pixel producer (drawing/fill logic) and the memory write port. It is the inverse of the read-side slot selector: the same slot mapping applies, with slot k occupying bits [3k+2:3k].

---
 rtl/pix_pack_pkg.sv | 22 ++
 rtl/pixel_pack_3to24_if.sv | 27 ++
 rtl/pix_slot_merge.sv | 24 ++
 rtl/pixel_pack_3to24.sv | 113 +++++++++++
 4 files changed

// File: rtl/pix_pack_pkg.sv
// Shared geometry, state encoding and slot mapping for the 3-bit pixel frame store.
package pix_pack_pkg;

  localparam int unsigned PIX_W   = 3;
  localparam int unsigned SLOTS   = 8;
  localparam int unsigned SLOT_W  = 3;
  localparam int unsigned WORD_W  = 24;
  localparam int unsigned PADDR_W = 19;
  localparam int unsigned WADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WRITE
  } state_e;

  // Slot k lives at bits [3k+2:3k]; the read-side selector uses the same mapping.
  function automatic int unsigned slot_lsb(input int unsigned slot);
    return slot * PIX_W;
  endfunction

endpackage

// File: rtl/pixel_pack_3to24_if.sv
// Pixel-in / masked-word-out bundle between the pixel producer, the packer and frame memory.
interface pixel_pack_3to24_if;
  import pix_pack_pkg::*;

  logic               pix_valid;
  logic               pix_ready;
  logic [PADDR_W-1:0] pix_addr;
  logic [PIX_W-1:0]   pix_data;
  logic               flush;
  logic               wr_valid;
  logic               wr_ready;
  logic [WADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0]  wr_data;
  logic [SLOTS-1:0]   wr_mask;
  logic               idle;

  modport slave (
    input  pix_valid, pix_addr, pix_data, flush, wr_ready,
    output pix_ready, wr_valid, wr_addr, wr_data, wr_mask, idle
  );

  modport master (
    output pix_valid, pix_addr, pix_data, flush, wr_ready,
    input  pix_ready, wr_valid, wr_addr, wr_data, wr_mask, idle
  );

endinterface

// File: rtl/pix_slot_merge.sv
// Combinational insertion of one pixel into a packed word and its slot mask.
module pix_slot_merge
  import pix_pack_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [SLOTS-1:0]  mask_i,
  input  logic [SLOT_W-1:0] slot_i,
  input  logic [PIX_W-1:0]  pix_i,
  output logic [WORD_W-1:0] word_c,
  output logic [SLOTS-1:0]  mask_c
);

  always_comb begin
    word_c = word_i;
    mask_c = mask_i;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (slot_i == SLOT_W'(k)) begin
        word_c[slot_lsb(k) +: PIX_W] = pix_i;
        mask_c[k]                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_pack_3to24.sv
// Packs eight 3-bit pixels of one word address into a single masked 24-bit memory write.
module pixel_pack_3to24
  import pix_pack_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  pixel_pack_3to24_if.slave  bus
);

  state_e               state_q, state_d;
  logic [WORD_W-1:0]    acc_word_q, acc_word_d;
  logic [SLOTS-1:0]     acc_mask_q, acc_mask_d;
  logic [WADDR_W-1:0]   acc_waddr_q, acc_waddr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 idle_q, idle_d;

  logic                 pix_ready_c;
  logic                 accept_c;
  logic                 close_c;
  logic [WADDR_W-1:0]   pix_waddr_c;
  logic [SLOT_W-1:0]    pix_slot_c;
  logic [WORD_W-1:0]    base_word_c, merged_word_c;
  logic [SLOTS-1:0]     base_mask_c, merged_mask_c;

  assign pix_waddr_c = bus.pix_addr[PADDR_W-1:SLOT_W];
  assign pix_slot_c  = bus.pix_addr[SLOT_W-1:0];

  // A pixel belongs to the held word only if its word address matches.
  always_comb begin
    pix_ready_c = 1'b0;
    case (state_q)
      IDLE:    pix_ready_c = 1'b1;
      ACCUM:   pix_ready_c = (pix_waddr_c == acc_waddr_q);
      default: pix_ready_c = 1'b0;
    endcase
  end

  assign accept_c = bus.pix_valid & pix_ready_c;
  // An accepted last-slot pixel or a concurrent flush closes the word including that pixel.
  assign close_c  = (pix_slot_c == SLOT_W'(SLOTS - 1)) | bus.flush;

  // A fresh word starts from an empty accumulator.
  assign base_word_c = (state_q == IDLE) ? '0 : acc_word_q;
  assign base_mask_c = (state_q == IDLE) ? '0 : acc_mask_q;

  pix_slot_merge u_merge (
    .word_i (base_word_c),
    .mask_i (base_mask_c),
    .slot_i (pix_slot_c),
    .pix_i  (bus.pix_data),
    .word_c (merged_word_c),
    .mask_c (merged_mask_c)
  );

  always_comb begin
    state_d     = state_q;
    acc_word_d  = acc_word_q;
    acc_mask_d  = acc_mask_q;
    acc_waddr_d = acc_waddr_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          acc_word_d  = merged_word_c;
          acc_mask_d  = merged_mask_c;
          acc_waddr_d = pix_waddr_c;
          state_d     = close_c ? WRITE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          acc_word_d = merged_word_c;
          acc_mask_d = merged_mask_c;
          if (close_c) state_d = WRITE;
        end else if (bus.flush || bus.pix_valid) begin
          // pix_valid without accept means a new word address: emit and leave it pending.
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.wr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_valid_d = (state_d == WRITE);
    idle_d     = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_word_q  <= '0;
      acc_mask_q  <= '0;
      acc_waddr_q <= '0;
      wr_valid_q  <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      acc_word_q  <= acc_word_d;
      acc_mask_q  <= acc_mask_d;
      acc_waddr_q <= acc_waddr_d;
      wr_valid_q  <= wr_valid_d;
      idle_q      <= idle_d;
    end
  end

  assign bus.pix_ready = pix_ready_c;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_addr   = acc_waddr_q;
  assign bus.wr_data   = acc_word_q;
  assign bus.wr_mask   = acc_mask_q;
  assign bus.idle      = idle_q;

endmodule
